// File: rtl/pc_fetch_if.sv
// Fetch-stage bundle: next-PC input, instruction-memory handshake and PC/instruction outputs.
// master = pc_fetch side, slave = surrounding pipeline / memory side.
interface pc_fetch_if;
  logic [31:0] next_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pc_Add4;
  logic [31:0] instruction;
  logic        inst_valid;
  logic [31:0] fetch_cnt;
  logic        addr_err;

  modport master (
    input  next_pc, stall, imem_ack, imem_rdata,
    output imem_req, imem_addr, pc, pc_Add4, instruction, inst_valid, fetch_cnt, addr_err
  );

  modport slave (
    output next_pc, stall, imem_ack, imem_rdata,
    input  imem_req, imem_addr, pc, pc_Add4, instruction, inst_valid, fetch_cnt, addr_err
  );
endinterface

// File: rtl/pc_fetch.sv
// Instruction fetch stage: holds the PC, issues one memory read per instruction, latches the word.
// Optional FETCH_ALIGN_CHK_EN: a misaligned next_pc on advance traps into a sticky error state.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input logic        clk,
  input logic        reset,
  pc_fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_VALID,
    S_ERR
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic [31:0] instr_q, instr_nxt;
  logic        valid_q, valid_nxt;
  logic [31:0] cnt_q, cnt_nxt;
  logic        aerr_q, aerr_nxt;
  logic        misaligned;

`ifdef FETCH_ALIGN_CHK_EN
  assign misaligned = (bus.next_pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      aerr_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc_q    <= pc_nxt;
      instr_q <= instr_nxt;
      valid_q <= valid_nxt;
      cnt_q   <= cnt_nxt;
      aerr_q  <= aerr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    instr_nxt = instr_q;
    valid_nxt = valid_q;
    cnt_nxt   = cnt_q;
    aerr_nxt  = aerr_q;
    unique case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (bus.imem_ack) begin
          instr_nxt = bus.imem_rdata;
          valid_nxt = 1'b1;
          state_nxt = S_VALID;
        end
      end
      S_VALID: begin
        if (!bus.stall) begin
          valid_nxt = 1'b0;
          if (misaligned) begin
            aerr_nxt  = 1'b1;
            state_nxt = S_ERR;
          end else begin
            // Low bits forced to zero so the PC stays word aligned even without checking.
            pc_nxt    = {bus.next_pc[31:2], 2'b00};
            cnt_nxt   = cnt_q + 32'd1;
            state_nxt = S_REQ;
          end
        end
      end
      S_ERR: valid_nxt = 1'b0;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.imem_req    = (state == S_REQ);
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.pc_Add4     = pc_q + 32'd4;
  assign bus.instruction = instr_q;
  assign bus.inst_valid  = valid_q;
  assign bus.fetch_cnt   = cnt_q;
`ifdef FETCH_ALIGN_CHK_EN
  assign bus.addr_err    = aerr_q;
`else
  assign bus.addr_err    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios then random traffic, all checked against a
// transaction-level model of the fetch stage.
module tb_pc_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  pc_fetch_if bus();

  pc_fetch #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FETCH_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  // Model: "started" = left the post-reset idle cycle, "have_word" = instruction held,
  // "trapped" = stuck after a misaligned advance. Waiting for memory is the remaining case.
  bit          m_started, m_have_word, m_trapped, m_aerr;
  logic [31:0] m_pc, m_instr, m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input bit stl, input bit ack,
                            input logic [31:0] rd, input logic [31:0] npc);
    if (!rst) begin
      m_started = 0; m_have_word = 0; m_trapped = 0; m_aerr = 0;
      m_pc = RST_PC; m_instr = '0; m_cnt = '0;
    end else if (!m_started) begin
      m_started = 1;
    end else if (m_trapped) begin
      m_have_word = 0;
    end else if (!m_have_word) begin
      if (ack) begin
        m_instr = rd;
        m_have_word = 1;
      end
    end else if (!stl) begin
      m_have_word = 0;
      if (ALIGN_CHK && (npc % 4 != 0)) begin
        m_aerr = 1;
        m_trapped = 1;
      end else begin
        m_pc  = npc - (npc % 4);
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic check_all();
    bit exp_req;
    exp_req = m_started && !m_have_word && !m_trapped;
    check("imem_req",    {31'd0, bus.imem_req},   {31'd0, exp_req});
    check("imem_addr",   bus.imem_addr,           m_pc);
    check("pc",          bus.pc,                  m_pc);
    check("pc_Add4",     bus.pc_Add4,             m_pc + 32'd4);
    check("instruction", bus.instruction,         m_instr);
    check("inst_valid",  {31'd0, bus.inst_valid}, {31'd0, m_have_word});
    check("fetch_cnt",   bus.fetch_cnt,           m_cnt);
    check("addr_err",    {31'd0, bus.addr_err},   {31'd0, m_aerr});
  endtask

  // Inputs change at the falling edge; outputs are checked at the next falling edge.
  task automatic step(input bit rst, input bit stl, input bit ack,
                      input logic [31:0] rd, input logic [31:0] npc);
    reset          = rst;
    bus.stall      = stl;
    bus.imem_ack   = ack;
    bus.imem_rdata = rd;
    bus.next_pc    = npc;
    @(posedge clk);
    model_edge(rst, stl, ack, rd, npc);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    step(0, 0, 0, '0, '0);
    step(0, 1, 1, 32'hDEAD_BEEF, 32'h1234_5678);
  endtask

  initial begin
    logic [31:0] npc;
    n_tests = 0;
    n_fail  = 0;
    m_pc = RST_PC; m_instr = '0; m_cnt = '0;
    reset = 1'b0; bus.stall = 1'b0; bus.imem_ack = 1'b0;
    bus.imem_rdata = '0; bus.next_pc = '0;
    @(negedge clk);

    // Reset state
    do_reset();
    check("rst_pc", bus.pc, RST_PC);
    check("rst_cnt", bus.fetch_cnt, 32'd0);

    // Zero-wait-state streaming: two cycles per instruction
    for (int i = 0; i < 5; i++) step(1, 0, 1, $urandom, m_pc + 32'd4);
    check("stream_pc", bus.pc, 32'h0000_3008);
    check("stream_cnt", bus.fetch_cnt, 32'd2);

    // Memory wait states
    do_reset();
    step(1, 0, 0, '0, '0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, $urandom, $urandom);
    check("wait_req", {31'd0, bus.imem_req}, 32'd1);
    check("wait_addr", bus.imem_addr, 32'h0000_3000);
    step(1, 0, 1, 32'h2408_0005, 32'h0);
    check("ack_instr", bus.instruction, 32'h2408_0005);
    check("ack_valid", {31'd0, bus.inst_valid}, 32'd1);

    // Stall hold then advance
    for (int i = 0; i < 3; i++) step(1, 1, 1, $urandom, 32'h0000_4000);
    check("stall_pc", bus.pc, 32'h0000_3000);
    step(1, 0, 0, '0, 32'h0000_4000);
    check("adv_pc", bus.pc, 32'h0000_4000);
    check("adv_cnt", bus.fetch_cnt, 32'd1);

    // pc_Add4 wrap and PC wrap to zero
    step(1, 0, 1, $urandom, '0);
    step(1, 0, 0, '0, 32'hFFFF_FFFC);
    check("wrap_add4", bus.pc_Add4, 32'h0000_0000);
    step(1, 0, 1, $urandom, '0);
    step(1, 0, 0, '0, m_pc + 32'd4);
    check("wrap_pc", bus.pc, 32'h0000_0000);

    // Self-loop still refetches
    step(1, 0, 1, 32'h1111_2222, '0);
    step(1, 0, 0, '0, m_pc);
    check("selfloop_req", {31'd0, bus.imem_req}, 32'd1);

    // Misaligned next_pc
    do_reset();
    step(1, 0, 0, '0, '0);
    step(1, 0, 1, $urandom, '0);
    step(1, 0, 0, '0, 32'h0000_3002);
    check("mis_pc", bus.pc, 32'h0000_3000);
    check("mis_aerr", {31'd0, bus.addr_err}, {31'd0, ALIGN_CHK});
    for (int i = 0; i < 4; i++) step(1, $urandom_range(0, 1), 1, $urandom, $urandom);

    // Reset overrides a same-cycle acknowledge; late ack in idle ignored
    do_reset();
    step(1, 0, 0, '0, '0);
    step(0, 0, 1, 32'hCAFE_F00D, '0);
    check("rst_ack_instr", bus.instruction, 32'h0);
    check("rst_ack_valid", {31'd0, bus.inst_valid}, 32'd0);
    step(1, 0, 1, 32'hCAFE_F00D, '0);
    check("late_ack_instr", bus.instruction, 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 5))
        0:       npc = $urandom;
        1:       npc = 32'hFFFF_FFFC;
        2:       npc = m_pc;
        default: npc = m_pc + 32'd4;
      endcase
      step($urandom_range(0, 63) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1, $urandom, npc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, SHALL be the PC value loaded on reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  SHALL be synchronous, active-low (0 = reset at next rising clk edge).
REQ-004 next_pc  in  32  next-PC value from the next-PC selector; sampled only on advance.
REQ-005 stall  in  1  downstream hold; 1 blocks PC advance.
REQ-006 imem_req  out  1  instruction-memory read request.
REQ-007 imem_addr  out  32  word address for the read; equals pc.
REQ-008 imem_ack  in  1  memory acknowledge; imem_rdata valid in the same cycle.
REQ-009 imem_rdata  in  32  instruction word from memory.
REQ-010 pc  out  32  current PC register.
REQ-011 pc_Add4  out  32  pc + 4, combinational, modulo 2^32.
REQ-012 instruction  out  32  latched instruction word.
REQ-013 inst_valid  out  1  instruction holds the word fetched from pc.
REQ-014 fetch_cnt  out  32  count of advanced (consumed) instructions.
REQ-015 addr_err  out  1  misaligned next_pc flag (see Configuration).

Function
REQ-016 States SHALL be IDLE, REQ, VALID, ERR; encoding is free.
REQ-017 IDLE -> REQ on the first rising edge with reset=1.
REQ-018 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc; imem_req SHALL be 0 in all other states.
REQ-019 REQ with imem_ack=1: instruction <= imem_rdata, inst_valid <= 1, -> VALID (data visible one cycle after ack).
REQ-020 REQ with imem_ack=0: hold REQ indefinitely; pc, instruction unchanged.
REQ-021 imem_ack outside REQ SHALL be ignored.
REQ-022 VALID with stall=1: hold all state; instruction and inst_valid stable.
REQ-023 VALID with stall=0 (advance): pc <= next_pc, inst_valid <= 0, fetch_cnt <= fetch_cnt + 1, -> REQ.
REQ-024 Minimum throughput SHALL be one instruction per 2 cycles with zero-wait-state memory.
REQ-025 pc_Add4 SHALL wrap: pc=32'hFFFF_FFFC gives pc_Add4=32'h0000_0000.
REQ-026 fetch_cnt SHALL wrap from 32'hFFFF_FFFF to 0 without side effect.
REQ-027 next_pc equal to pc on advance (self-loop) SHALL still issue a new fetch.
REQ-028 ERR SHALL be exited only by reset; imem_req=0, inst_valid=0, pc frozen.

Reset
REQ-029 On a rising edge with reset=0: state=IDLE, pc=RESET_PC, instruction=0, inst_valid=0, fetch_cnt=0, addr_err=0.
REQ-030 Reset mid-fetch (REQ or VALID) SHALL abandon the request; a late imem_ack after reset SHALL be ignored while in IDLE.
REQ-031 reset SHALL override stall, imem_ack and ERR in the same cycle.

Configuration
REQ-032 Macro FETCH_ALIGN_CHK_EN selects misalignment checking.
REQ-033 Defined: advance with next_pc[1:0]!=0 SHALL set addr_err=1 (sticky), leave pc unchanged, not count, -> ERR.
REQ-034 Undefined: advance SHALL load {next_pc[31:2],2'b00}; addr_err SHALL be tied 0; ERR unreachable.

Verification
REQ-035 Reset, release, imem_ack=1 always, stall=0, next_pc=pc_Add4 -> pc 0x3000,0x3004,0x3008 every 2 cycles; fetch_cnt=2 after second advance.
REQ-036 imem_ack held 0 for 5 cycles in REQ -> imem_req=1, imem_addr=0x3000 stable; ack then inst_valid=1 next cycle with instruction=imem_rdata (e.g. 0x2408_0005).
REQ-037 In VALID, stall=1 for 3 cycles with next_pc=0x4000 -> pc stays 0x3000; stall=0 -> pc=0x4000 next edge, fetch_cnt+1.
REQ-038 pc forced via next_pc=0xFFFF_FFFC -> pc_Add4=0; advance with next_pc=pc_Add4 -> pc=0x0000_0000.
REQ-039 next_pc=0x3002 on advance: with FETCH_ALIGN_CHK_EN -> addr_err=1, ERR, pc holds, imem_req=0; without -> pc=0x3000, addr_err=0.
REQ-040 reset=0 asserted during REQ with imem_ack=1 same cycle -> next edge state IDLE, inst_valid=0, pc=RESET_PC, instruction=0.
